// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - three-port AXI3 read arbiter with fixed priority and prefetch anti-starvation
module axi_rd_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [95:0] addr,
    input  logic [23:0] len,
    output logic [2:0]  addr_ok,
    output logic [2:0]  data_valid,
    output logic [2:0]  data_last,
    output logic        data_err,
    output logic [31:0] data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic [1:0]        winner;
    logic [31:0]       sel_addr;
    logic [7:0]        sel_len;
    logic              beat_ok;

    // Prefetch overrides fixed priority only once it has been passed over STARVE_LIMIT times.
    always_comb begin
        winner = 2'd0;
        if (req[2] && (starve_cnt_q >= LIMIT)) winner = 2'd2;
        else if (req[0])                       winner = 2'd0;
        else if (req[1])                       winner = 2'd1;
        else if (req[2])                       winner = 2'd2;
    end

    always_comb begin
        sel_addr = addr[31:0];
        sel_len  = len[7:0];
        case (winner)
            2'd1:    begin sel_addr = addr[63:32]; sel_len = len[15:8];  end
            2'd2:    begin sel_addr = addr[95:64]; sel_len = len[23:16]; end
            default: begin sel_addr = addr[31:0];  sel_len = len[7:0];   end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        starve_cnt_d = starve_cnt_q;
        addr_ok      = 3'b000;
        data_valid   = 3'b000;
        data_last    = 3'b000;
        data_err     = 1'b0;
        data         = 32'd0;
        arid         = 4'd0;
        araddr       = 32'd0;
        arlen        = 8'd0;
        arsize       = 3'd0;
        arburst      = 2'b00;
        arlock       = 2'b00;
        arcache      = 4'd0;
        arprot       = 3'd0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        beat_ok      = 1'b0;
        // Outputs are forced quiet for the whole reset cycle, not just after it.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        addr_ok = 3'b001 << winner;
                        grant_d = winner;
                        addr_d  = sel_addr;
                        len_d   = sel_len;
                        if (winner == 2'd2)
                            starve_cnt_d = '0;
                        else if (req[2] && (starve_cnt_q < LIMIT))
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        state_d = AR;
                    end
                end
                AR: begin
                    arvalid = 1'b1;
                    arid    = {2'b00, grant_q};
                    araddr  = addr_q;
                    arlen   = len_q;
                    arsize  = 3'd2;
                    arburst = 2'b01;
                    if (arready) state_d = R;
                end
                R: begin
                    rready  = 1'b1;
                    beat_ok = rvalid && (rid == {2'b00, grant_q});
                    if (beat_ok) begin
                        data_valid = 3'b001 << grant_q;
                        data_last  = {2'b00, rlast} << grant_q;
                        data       = rdata;
                        data_err   = (rresp != 2'b00);
                        if (rlast) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            addr_q       <= 32'd0;
            len_q        <= 8'd0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - randomized and directed bench for axi_rd_arbiter against a burst-level model
module tb_axi_rd_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [95:0] addr;
    logic [23:0] len;
    logic [2:0]  addr_ok, data_valid, data_last;
    logic        data_err;
    logic [31:0] data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    axi_rd_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .len(len),
        .addr_ok(addr_ok), .data_valid(data_valid), .data_last(data_last),
        .data_err(data_err), .data(data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    // Model: one record for the burst in flight plus the starvation count.
    bit          m_busy, m_arpend;
    int          m_port, m_len, m_left, m_starve;
    logic [31:0] m_addr;
    int          grant_log[$];
    int          starve_log[$];

    // Stimulus knobs: en 0=off, 1=random, 2=continuous, 3=one-shot
    int          en[3];
    bit          use_fix[3];
    logic [31:0] fix_addr[3];
    int          fix_len[3];
    int          rv_pct, ar_pct, bad_pct, err_pct, rst_pct, ar_low, rst_beat, err_beat, rst_hold;
    logic [2:0]  ok_seen;

    int          dv_cnt[3], dl_cnt[3], err_cnt, arv_cnt, dv_at_last;
    logic [31:0] first_araddr;
    bit          got_araddr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
        if (r[2] && m_starve >= LIMIT) return 2;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return 2;
    endfunction

    task automatic clr_counts();
        for (int p = 0; p < 3; p++) begin dv_cnt[p] = 0; dl_cnt[p] = 0; end
        err_cnt = 0; arv_cnt = 0; dv_at_last = 0; got_araddr = 0; first_araddr = 0;
        grant_log.delete(); starve_log.delete();
    endtask

    task automatic step();
        logic [2:0]  e_ok, e_dv, e_dl;
        logic        e_arv, e_rr, e_err;
        logic [31:0] e_araddr, e_data;
        logic [7:0]  e_arlen;
        logic [3:0]  e_arid;
        logic [2:0]  e_arsize;
        logic [1:0]  e_arburst;
        int          w, beatno;
        bit          dropped;

        @(negedge clk);
        e_ok = 0; e_dv = 0; e_dl = 0; e_arv = 0; e_rr = 0; e_err = 0;
        e_araddr = 0; e_data = 0; e_arlen = 0; e_arid = 0; e_arsize = 0; e_arburst = 0;
        w = pick(req);
        if (rst) begin
        end else if (!m_busy) begin
            if (|req) e_ok = 3'b001 << w;
        end else if (m_arpend) begin
            e_arv = 1; e_araddr = m_addr; e_arlen = 8'(m_len); e_arid = 4'(m_port);
            e_arsize = 3'd2; e_arburst = 2'b01;
        end else begin
            e_rr = 1;
            if (rvalid && rid == 4'(m_port)) begin
                e_dv = 3'b001 << m_port;
                e_dl = rlast ? (3'b001 << m_port) : 3'b000;
                e_err = (rresp != 0);
                e_data = rdata;
            end
        end
        chk("addr_ok", 32'(addr_ok), 32'(e_ok));
        chk("arvalid", 32'(arvalid), 32'(e_arv));
        chk("araddr", araddr, e_araddr);
        chk("arlen", 32'(arlen), 32'(e_arlen));
        chk("arid", 32'(arid), 32'(e_arid));
        chk("arsize", 32'(arsize), 32'(e_arsize));
        chk("arburst", 32'(arburst), 32'(e_arburst));
        chk("ar_fixed", {23'd0, arlock, arcache, arprot}, 32'd0);
        chk("rready", 32'(rready), 32'(e_rr));
        chk("data_valid", 32'(data_valid), 32'(e_dv));
        chk("data_last", 32'(data_last), 32'(e_dl));
        chk("data_err", 32'(data_err), 32'(e_err));
        if (e_dv != 0) chk("data", data, e_data);

        for (int p = 0; p < 3; p++) begin
            if (data_valid[p]) dv_cnt[p]++;
            if (data_last[p]) begin dl_cnt[p]++; dv_at_last = dv_cnt[p]; end
        end
        if (data_err) err_cnt++;
        if (arvalid) begin
            arv_cnt++;
            if (!got_araddr) begin first_araddr = araddr; got_araddr = 1; end
        end
        ok_seen = addr_ok;

        if (rst) begin
            m_busy = 0; m_arpend = 0; m_starve = 0;
        end else if (!m_busy && |req) begin
            m_busy = 1; m_arpend = 1; m_port = w;
            m_addr = addr[32*w +: 32]; m_len = int'(len[8*w +: 8]); m_left = m_len + 1;
            grant_log.push_back(w); starve_log.push_back(m_starve);
            if (w == 2) m_starve = 0;
            else if (req[2]) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        end else if (m_busy && m_arpend) begin
            if (arready) m_arpend = 0;
        end else if (m_busy && rvalid && rid == 4'(m_port)) begin
            m_left--;
            if (rlast) m_busy = 0;
        end

        @(posedge clk);
        #1;
        beatno = m_len + 2 - m_left;
        rst = 0;
        if (rst_hold > 0) begin rst = 1; rst_hold--; end
        else if (rst_pct > 0 && $urandom_range(999) < rst_pct) rst = 1;

        for (int p = 0; p < 3; p++) begin
            dropped = 0;
            if (ok_seen[p]) begin
                req[p] = 0; dropped = (en[p] != 2);
                if (en[p] == 3) en[p] = 0;
            end else if (en[p] == 0) begin
                req[p] = 0;
            end else if (req[p] && en[p] == 1 && $urandom_range(63) == 0) begin
                req[p] = 0; dropped = 1;
            end
            if (!req[p] && !dropped &&
                (en[p] >= 2 || (en[p] == 1 && $urandom_range(99) < 20))) begin
                req[p] = 1;
                addr[32*p +: 32] = use_fix[p] ? fix_addr[p] : $urandom;
                len[8*p +: 8]    = use_fix[p] ? 8'(fix_len[p]) : 8'($urandom_range(7));
            end
        end

        arready = 0; rvalid = 0; rid = 0; rlast = 0; rresp = 0; rdata = $urandom;
        if (m_busy && m_arpend) begin
            if (ar_low > 0) ar_low--;
            else arready = ($urandom_range(99) < ar_pct);
        end else if (m_busy) begin
            rvalid = ($urandom_range(99) < rv_pct);
            if (rvalid && $urandom_range(99) < bad_pct) begin
                rid = 4'((m_port + 1) % 3);
                rlast = 1'($urandom_range(1));
                rresp = 2'($urandom_range(3));
            end else if (rvalid) begin
                rid = 4'(m_port);
                rlast = (m_left == 1);
                if (err_beat != 0) rresp = (beatno == err_beat) ? 2'b10 : 2'b00;
                else if ($urandom_range(99) < err_pct) rresp = 2'($urandom_range(1, 3));
                if (rst_beat != 0 && beatno == rst_beat) begin rst = 1; rst_beat = 0; end
            end
        end
    endtask

    task automatic drain();
        int n;
        for (int p = 0; p < 3; p++) begin en[p] = 0; use_fix[p] = 0; end
        n = 0;
        step();
        while ((m_busy || req != 0) && n < 500) begin step(); n++; end
        chk("drain_done", 32'(n < 500), 32'd1);
        step();
    endtask

    task automatic run_until_grants(input int ng, input int budget);
        int n;
        n = 0;
        while (grant_log.size() < ng && n < budget) begin step(); n++; end
        chk("grant_budget", 32'(n < budget), 32'd1);
    endtask

    int exp_pat[10];

    initial begin
        rst = 1; req = 0; addr = 0; len = 0; arready = 0; rid = 0; rdata = 0;
        rresp = 0; rlast = 0; rvalid = 0; ok_seen = 0;
        m_busy = 0; m_arpend = 0; m_port = 0; m_len = 0; m_left = 0; m_starve = 0; m_addr = 0;
        for (int p = 0; p < 3; p++) begin en[p] = 0; use_fix[p] = 0; fix_addr[p] = 0; fix_len[p] = 0; end
        rv_pct = 100; ar_pct = 100; bad_pct = 0; err_pct = 0; rst_pct = 0;
        ar_low = 0; rst_beat = 0; err_beat = 0; rst_hold = 2;
        clr_counts();
        for (int i = 0; i < 4; i++) step();

        // Single dcache refill of 8 beats.
        clr_counts();
        use_fix[0] = 1; fix_addr[0] = 32'h1FC0_0100; fix_len[0] = 7; en[0] = 3;
        run_until_grants(1, 50);
        drain();
        chk("p1_araddr", first_araddr, 32'h1FC0_0100);
        chk("p1_arvalid_cycles", 32'(arv_cnt), 32'd1);
        chk("p1_beats", 32'(dv_cnt[0]), 32'd8);
        chk("p1_last_cnt", 32'(dl_cnt[0]), 32'd1);
        chk("p1_last_on_8th", 32'(dv_at_last), 32'd8);

        // All three requesting together, each once.
        clr_counts();
        en[0] = 3; en[1] = 3; en[2] = 3;
        run_until_grants(3, 300);
        drain();
        chk("p2_size", 32'(grant_log.size()), 32'd3);
        chk("p2_g0", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
        chk("p2_g1", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd1);
        chk("p2_g2", 32'(grant_log.size() > 2 ? grant_log[2] : -1), 32'd2);
        chk("p2_starve_before_2", 32'(starve_log.size() > 2 ? starve_log[2] : -1), 32'd2);

        // Dcache and prefetch hammering continuously.
        clr_counts();
        en[0] = 2; en[2] = 2;
        run_until_grants(10, 2000);
        drain();
        exp_pat = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
        for (int i = 0; i < 10; i++)
            chk($sformatf("p3_grant%0d", i), 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(exp_pat[i]));

        // arready stalled for 5 cycles.
        clr_counts();
        ar_low = 5; en[1] = 3;
        run_until_grants(1, 50);
        drain();
        chk("p4_arvalid_cycles", 32'(arv_cnt), 32'd6);

        // Foreign-rid beats injected into a port-1 burst.
        clr_counts();
        use_fix[1] = 1; fix_addr[1] = 32'h0000_4000; fix_len[1] = 3; en[1] = 3;
        bad_pct = 40;
        run_until_grants(1, 50);
        drain();
        bad_pct = 0;
        chk("p5_beats", 32'(dv_cnt[1]), 32'd4);
        chk("p5_other_dv", 32'(dv_cnt[0] + dv_cnt[2]), 32'd0);

        // Reset on beat 3 of a len-3 burst with an error response on beat 2.
        clr_counts();
        use_fix[0] = 1; fix_addr[0] = 32'h0000_8000; fix_len[0] = 3; en[0] = 3;
        rst_beat = 3; err_beat = 2;
        run_until_grants(1, 50);
        drain();
        err_beat = 0; rst_beat = 0;
        chk("p6_err_cnt", 32'(err_cnt), 32'd1);
        chk("p6_beats_before_rst", 32'(dv_cnt[0]), 32'd2);
        chk("p6_last_cnt", 32'(dl_cnt[0]), 32'd0);
        clr_counts();
        use_fix[1] = 1; fix_addr[1] = 32'h0000_9000; fix_len[1] = 2; en[1] = 3;
        run_until_grants(1, 50);
        drain();
        chk("p6_post_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        chk("p6_post_beats", 32'(dv_cnt[1]), 32'd3);

        // Free-running random traffic.
        clr_counts();
        en[0] = 1; en[1] = 1; en[2] = 1;
        rv_pct = 70; ar_pct = 60; bad_pct = 10; err_pct = 25; rst_pct = 2;
        for (int i = 0; i < 4000; i++) step();
        rst_pct = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI3 read master port among three cache-side requesters:
  - port 0: dcache refill
  - port 1: icache refill
  - port 2: stream-buffer prefetch
- Runs one outstanding burst at a time. Routes R beats back to the granted requester.
- Fixed priority 0 > 1 > 2, with a starvation counter so prefetch is still served under heavy refill traffic.

Parameters:
- STARVE_LIMIT, 4, number of consecutive grants to ports 0/1 while req[2] is pending, after which port 2 wins the next arbitration.
- CNT_W, 3, width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst synchronous, active-high; clock clk
- req  in  3  per-port read request; held until the matching addr_ok
- addr  in  96  per-port byte address; port i uses bits [32i+31:32i]
- len  in  24  per-port AXI arlen; port i uses bits [8i+7:8i]
- addr_ok  out  3  one-cycle per-port acceptance pulse
- data_valid  out  3  per-port beat valid
- data_last  out  3  per-port last beat
- data_err  out  1  rresp != 0 on the current forwarded beat
- data  out  32  shared beat data (rdata pass-through)
- arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out  4/32/8/3/2/2/4/3/1  AXI AR channel
- arready  in  1  AXI AR ready
- rid, rdata, rresp, rlast, rvalid  in  4/32/2/1/1  AXI R channel
- rready  out  1  AXI R ready

Behaviour:
- States: IDLE, AR, R. Reset value IDLE.
- Reset outputs: arvalid=0, rready=0, addr_ok=0, data_valid=0, data_last=0, grant=0, starve_cnt=0.
- rst mid-burst:
  - Returns to IDLE next cycle.
  - Any burst in flight is abandoned; the system reset also resets the AXI slave.
- IDLE with any req:
  - Winner = 2 if req[2] && starve_cnt >= STARVE_LIMIT.
  - Otherwise the lowest-index asserted req.
  - Same cycle: addr_ok[winner]=1 (combinational).
  - Registers latch grant, addr, len. Next state AR.
- IDLE with no req: stay in IDLE; all outputs 0.
- Starvation counter, updated at each grant:
  - Winner 2: starve_cnt <= 0.
  - Winner 0/1 with req[2] high: starve_cnt <= starve_cnt+1, saturating at STARVE_LIMIT.
  - Winner 0/1 with req[2] low: unchanged.
- AR state:
  - arvalid=1, araddr=latched addr, arlen=latched len, arid={2'b0,grant}.
  - Fixed fields: arsize=3'd2, arburst=2'b01, arlock=0, arcache=0, arprot=0.
  - AR fields are held stable while arvalid && !arready.
  - arvalid && arready -> R next cycle.
- R state:
  - rready=1.
  - Beat accepted when rvalid && rid == {2'b0,grant}. Then, combinationally in the same cycle:
    - data_valid[grant]=1
    - data=rdata
    - data_err=(rresp!=0)
    - data_last[grant]=rlast
  - A beat with a mismatched rid is consumed (rready=1) but not forwarded: data_valid stays 0.
  - Accepted beat with rlast=1 -> IDLE next cycle.
- Throughput:
  - Minimum turnaround between bursts is one IDLE cycle.
  - Back-to-back latency is req -> arvalid in 1 cycle.
- Requests asserted during AR/R:
  - Wait for IDLE; no addr_ok is issued outside IDLE.
  - A requester dropping req before addr_ok is legal; its request is simply not served.
- data is valid only when some data_valid bit is set; otherwise it is don't-care.
- Write channels are outside this block.

Test Plan:
- Single port-0 request, addr 0x1FC0_0100, len 7, arready=1, 8 beats with rlast on the 8th:
  - addr_ok[0] in the request cycle, arvalid the next cycle.
  - data_valid[0] on 8 beats, data_last[0] on the 8th, then back to IDLE.
- req=3'b111 in the same cycle, starve_cnt=0:
  - Grant order 0, 1 (port 0 drops req after its burst), then 2.
  - arid = 0, 1, 2 respectively.
  - starve_cnt is 2 before port 2 is granted, then 0.
- Ports 0 and 2 requesting continuously, STARVE_LIMIT=4:
  - Grants: 0,0,0,0 then 2, repeating.
- arready held low for 5 cycles:
  - arvalid, araddr and arlen stable for all 5 cycles.
  - No addr_ok pulses during AR.
- During an R burst for grant 1, inject a beat with rid=0:
  - rready=1, data_valid=000.
  - The following rid=1 beats are forwarded normally.
- rst asserted on the 3rd beat of a len-3 burst, with rresp=2'b10 on beat 2:
  - data_err=1 on beat 2 only.
  - After rst: state IDLE, all outputs 0, starve_cnt=0.
  - A new port-1 request is then served normally.
